// File: rtl/ws281x_rx.sv
// WS281x single-wire receiver: classifies high-pulse widths into bits and emits 24-bit GRB words on valid/ready.
// Optional pixel-chain forwarding on dout_o when WS281X_RX_PASSTHRU_EN is defined; otherwise dout_o is tied low.
module ws281x_rx #(
    parameter int unsigned BitThreshCycles = 15,
    parameter int unsigned MinHighCycles   = 4,
    parameter int unsigned MaxHighCycles   = 30,
    parameter int unsigned ResetCycles     = 1250,
    parameter int unsigned CntWidth        = 11
) (
    input  logic        main_clk_buf,
    input  logic        rst_sys_n,
    input  logic        din_i,
    output logic [23:0] data_o,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    output logic        data_first_o,
    output logic        frame_end_o,
    output logic        err_o,
    output logic        overflow_o,
    output logic        dout_o
);

    localparam int unsigned LenW = CntWidth + 1;
    localparam logic [CntWidth-1:0] CntSat = CntWidth'(ResetCycles);
    localparam logic [CntWidth-1:0] CntGap = CntWidth'(ResetCycles - 1);
    localparam logic [LenW-1:0]     MinLen = LenW'(MinHighCycles);
    localparam logic [LenW-1:0]     ThrLen = LenW'(BitThreshCycles);
    localparam logic [LenW-1:0]     MaxLen = LenW'(MaxHighCycles);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic                din_m_q, din_s_q, din_p_q;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [22:0]         shreg_q, shreg_d;
    logic                first_q, first_d;
    logic                active_q, active_d;
    logic [23:0]         data_q, data_d;
    logic                valid_q, valid_d;
    logic                dfirst_q, dfirst_d;
    logic                err_q, fend_q, ovf_q;

    logic            din_edge, rise, fall, gap_hit;
    logic [LenW-1:0] hi_len;
    logic            gap_ev, err_ev, fend_ev, ovf_ev, shift_en, bit_v, word_done;
    logic [23:0]     new_word;

    assign din_edge = din_s_q ^ din_p_q;
    assign rise     = din_s_q & ~din_p_q;
    assign fall     = ~din_s_q & din_p_q;
    // hi_len is the number of cycles din_s has been high, valid on the falling-edge cycle
    assign hi_len   = LenW'(cnt_q) + LenW'(1);
    // fires exactly once per low stretch, on the cycle the counter steps into saturation
    assign gap_hit  = ~din_s_q & ~din_edge & (cnt_q == CntGap);
    assign cnt_d    = din_edge ? '0 : ((cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1);

    always_ff @(posedge main_clk_buf or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            din_m_q <= 1'b0;
            din_s_q <= 1'b0;
            din_p_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            din_m_q <= din_i;
            din_s_q <= din_m_q;
            din_p_q <= din_s_q;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge main_clk_buf or negedge rst_sys_n) begin
        if (!rst_sys_n) state_q <= SYNC;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SYNC: if (gap_hit) state_d = LOW;
            LOW:  if (rise) state_d = HIGH;
            HIGH: begin
                if ((hi_len >= MaxLen) || (fall && (hi_len < MinLen))) state_d = SYNC;
                else if (fall)                                          state_d = LOW;
            end
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        gap_ev   = 1'b0;
        err_ev   = 1'b0;
        fend_ev  = 1'b0;
        ovf_ev   = 1'b0;
        shift_en = 1'b0;
        bit_v    = (hi_len >= ThrLen);
        unique case (state_q)
            SYNC: gap_ev = gap_hit;
            LOW: begin
                if (gap_hit) begin
                    gap_ev  = 1'b1;
                    err_ev  = (bit_cnt_q != 5'd0);
                    fend_ev = active_q;
                end
            end
            HIGH: begin
                if (hi_len >= MaxLen) err_ev = 1'b1;
                else if (fall) begin
                    if (hi_len < MinLen) err_ev   = 1'b1;
                    else                 shift_en = 1'b1;
                end
            end
            default: ;
        endcase

        word_done = shift_en && (bit_cnt_q == 5'd23);
        new_word  = {shreg_q, bit_v};

        shreg_d   = shift_en ? new_word[22:0] : shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (gap_ev || (state_d == SYNC)) bit_cnt_d = 5'd0;
        else if (shift_en)               bit_cnt_d = word_done ? 5'd0 : bit_cnt_q + 5'd1;

        first_d = first_q;
        if (gap_ev)         first_d = 1'b1;
        else if (word_done) first_d = 1'b0;

        active_d = active_q;
        if (gap_ev)        active_d = 1'b0;
        else if (shift_en) active_d = 1'b1;

        valid_d  = valid_q & ~data_ready_i;
        data_d   = data_q;
        dfirst_d = dfirst_q;
        if (word_done) begin
            if (!valid_q || data_ready_i) begin
                data_d   = new_word;
                valid_d  = 1'b1;
                dfirst_d = first_q;
            end else begin
                ovf_ev = 1'b1;
            end
        end
    end

    always_ff @(posedge main_clk_buf or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            first_q   <= 1'b0;
            active_q  <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            dfirst_q  <= 1'b0;
            err_q     <= 1'b0;
            fend_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            first_q   <= first_d;
            active_q  <= active_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            dfirst_q  <= dfirst_d;
            err_q     <= err_ev;
            fend_q    <= fend_ev;
            ovf_q     <= ovf_ev;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign data_first_o = dfirst_q;
    assign err_o        = err_q;
    assign frame_end_o  = fend_q;
    assign overflow_o   = ovf_q;

`ifdef WS281X_RX_PASSTHRU_EN
    logic fwd_q, fwd_d, dout_q, to_sync;

    assign to_sync = (state_q != SYNC) && (state_d == SYNC);

    // the first word of each frame is absorbed; everything after it is repeated downstream
    always_comb begin
        fwd_d = fwd_q;
        if (gap_ev || to_sync)        fwd_d = 1'b0;
        else if (word_done && first_q) fwd_d = 1'b1;
    end

    always_ff @(posedge main_clk_buf or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            fwd_q  <= 1'b0;
            dout_q <= 1'b0;
        end else begin
            fwd_q  <= fwd_d;
            dout_q <= fwd_q & din_s_q;
        end
    end

    assign dout_o = dout_q;
`else
    assign dout_o = 1'b0;
`endif

endmodule

// File: tb/tb_ws281x_rx.sv
// Self-checking bench for ws281x_rx: directed scenarios plus randomized frames against a word-level model.
`timescale 1ns/1ps
module tb_ws281x_rx;

    logic        main_clk_buf = 1'b0;
    logic        rst_sys_n;
    logic        din_i;
    logic [23:0] data_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic        data_first_o;
    logic        frame_end_o;
    logic        err_o;
    logic        overflow_o;
    logic        dout_o;

    ws281x_rx dut (
        .main_clk_buf (main_clk_buf),
        .rst_sys_n    (rst_sys_n),
        .din_i        (din_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .data_first_o (data_first_o),
        .frame_end_o  (frame_end_o),
        .err_o        (err_o),
        .overflow_o   (overflow_o),
        .dout_o       (dout_o)
    );

    always #20 main_clk_buf = ~main_clk_buf;

    int checks = 0;
    int errors = 0;

    int n_err = 0, n_fend = 0, n_ovf = 0, n_long = 0;
    logic err_p = 1'b0, fend_p = 1'b0, ovf_p = 1'b0;
    logic [24:0] hs_q[$];
    logic        din_h[$];
    logic        dout_h[$];

    always @(negedge main_clk_buf) begin
        din_h.push_back(din_i);
        dout_h.push_back(dout_o);
        if (err_o) n_err++;
        if (frame_end_o) n_fend++;
        if (overflow_o) n_ovf++;
        if ((err_o && err_p) || (frame_end_o && fend_p) || (overflow_o && ovf_p)) n_long++;
        if (data_valid_o && data_ready_i) hs_q.push_back({data_first_o, data_o});
        err_p  = err_o;
        fend_p = frame_end_o;
        ovf_p  = overflow_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        din_i = lvl;
        repeat (n) begin
            @(posedge main_clk_buf);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int hi, input int lo);
        drive(1'b1, hi);
        drive(1'b0, lo);
    endtask

    // mode 0: nominal 20/11 and 10/21; mode 1: random legal widths; mode 2: threshold-edge widths
    task automatic send_word(input logic [23:0] w, input int mode);
        int hi, lo;
        for (int i = 23; i >= 0; i--) begin
            case (mode)
                1: begin
                    hi = w[i] ? int'($urandom_range(15, 29)) : int'($urandom_range(4, 14));
                    lo = int'($urandom_range(2, 40));
                end
                2: begin
                    hi = w[i] ? ((i % 2) ? 15 : 29) : ((i % 2) ? 14 : 4);
                    lo = 12;
                end
                default: begin
                    hi = w[i] ? 20 : 10;
                    lo = w[i] ? 11 : 21;
                end
            endcase
            send_bit(w[i], hi, lo);
        end
    endtask

    int s_err, s_fend, s_ovf, s_hs, base, cnt, mism, nw, s_pt;
    logic [23:0] w;
    logic [24:0] exp_q[$];

    initial begin
        rst_sys_n    = 1'b0;
        din_i        = 1'b0;
        data_ready_i = 1'b0;
        repeat (5) @(posedge main_clk_buf);
        #1;
        chk("reset_outputs", {2'b0, data_o, data_valid_o, data_first_o, frame_end_o,
                              err_o, overflow_o, dout_o}, 32'h0);
        rst_sys_n = 1'b1;

        // single word after the power-up gap
        data_ready_i = 1'b1;
        drive(1'b0, 1250);
        s_hs = hs_q.size(); s_err = n_err; s_fend = n_fend;
        send_word(24'hA5C33C, 0);
        chk("t1_words", hs_q.size() - s_hs, 1);
        chk("t1_word", hs_q[hs_q.size() - 1], {1'b1, 24'hA5C33C});
        drive(1'b0, 1300);
        chk("t1_frame_end", n_fend - s_fend, 1);
        chk("t1_no_err", n_err - s_err, 0);

        // overflow: consumer stalled across two words
        data_ready_i = 1'b0;
        s_ovf = n_ovf; s_hs = hs_q.size();
        send_word(24'h00FF00, 0);
        send_word(24'h123456, 0);
        chk("t2_overflow", n_ovf - s_ovf, 1);
        chk("t2_valid_held", data_valid_o, 1);
        chk("t2_data_held", data_o, 24'h00FF00);
        chk("t2_first_held", data_first_o, 1);
        data_ready_i = 1'b1;
        @(posedge main_clk_buf); #1;
        chk("t2_valid_drop", data_valid_o, 0);
        chk("t2_one_consumed", hs_q.size() - s_hs, 1);
        drive(1'b0, 1300);

        // consume and load in the same cycle
        data_ready_i = 1'b0;
        s_ovf = n_ovf; s_hs = hs_q.size();
        send_word(24'h00FF00, 0);
        w = 24'h123456;
        for (int i = 23; i >= 1; i--) send_bit(w[i], w[i] ? 20 : 10, w[i] ? 11 : 21);
        drive(1'b1, w[0] ? 20 : 10);
        din_i = 1'b0;
        @(posedge main_clk_buf); #1;
        @(posedge main_clk_buf); #1;
        data_ready_i = 1'b1;
        @(posedge main_clk_buf); #1;
        data_ready_i = 1'b0;
        chk("t3_valid", data_valid_o, 1);
        chk("t3_data", data_o, 24'h123456);
        chk("t3_first", data_first_o, 0);
        chk("t3_no_overflow", n_ovf - s_ovf, 0);
        chk("t3_consumed_first", hs_q[hs_q.size() - 1], {1'b1, 24'h00FF00});
        data_ready_i = 1'b1;
        drive(1'b0, 1300);

        // partial word cut by a reset gap
        s_err = n_err; s_fend = n_fend; s_hs = hs_q.size();
        for (int i = 0; i < 12; i++) send_bit(i[0], i[0] ? 20 : 10, i[0] ? 11 : 21);
        drive(1'b0, 1300);
        chk("t4_err", n_err - s_err, 1);
        chk("t4_frame_end", n_fend - s_fend, 1);
        chk("t4_no_word", hs_q.size() - s_hs, 0);
        send_word(24'hC0FFEE, 0);
        drive(1'b0, 1300);
        chk("t4_next_word", hs_q[hs_q.size() - 1], {1'b1, 24'hC0FFEE});

        // glitch pulse: ignored until a full gap
        s_err = n_err; s_fend = n_fend; s_hs = hs_q.size();
        send_bit(1'b1, 20, 11);
        send_bit(1'b1, 20, 11);
        drive(1'b1, 2); drive(1'b0, 20);
        chk("t5_glitch_err", n_err - s_err, 1);
        send_word(24'h111111, 0);
        drive(1'b0, 1300);
        chk("t5_glitch_no_word", hs_q.size() - s_hs, 0);
        chk("t5_sync_no_frame_end", n_fend - s_fend, 0);
        send_word(24'h5A5A5A, 0);
        drive(1'b0, 1300);
        chk("t5_glitch_recover", hs_q[hs_q.size() - 1], {1'b1, 24'h5A5A5A});

        // over-long pulse
        s_err = n_err; s_hs = hs_q.size();
        drive(1'b1, 35); drive(1'b0, 20);
        chk("t5_long_err", n_err - s_err, 1);
        send_word(24'h222222, 0);
        drive(1'b0, 1300);
        chk("t5_long_no_word", hs_q.size() - s_hs, 0);
        send_word(24'h654321, 0);
        drive(1'b0, 1300);
        chk("t5_long_recover", hs_q[hs_q.size() - 1], {1'b1, 24'h654321});

        // width boundaries: 4/14 decode 0, 15/29 decode 1, 3 and 30 are errors
        send_word(24'h96C35A, 2);
        drive(1'b0, 1300);
        chk("bnd_word", hs_q[hs_q.size() - 1], {1'b1, 24'h96C35A});
        s_err = n_err;
        drive(1'b1, 3); drive(1'b0, 1300);
        chk("bnd_min_err", n_err - s_err, 1);
        s_err = n_err;
        drive(1'b1, 30); drive(1'b0, 1300);
        chk("bnd_max_err", n_err - s_err, 1);

        // randomized frames against the word-level model
        base = hs_q.size();
        exp_q.delete();
        for (int f = 0; f < 3; f++) begin
            nw = int'($urandom_range(1, 3));
            for (int k = 0; k < nw; k++) begin
                w = 24'($urandom);
                exp_q.push_back({(k == 0), w});
                send_word(w, 1);
            end
            drive(1'b0, 1300);
        end
        chk("rnd_count", hs_q.size() - base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (base + k < hs_q.size()) chk("rnd_word", hs_q[base + k], exp_q[k]);

        // reset mid-word
        for (int i = 0; i < 12; i++) send_bit(1'b1, 20, 11);
        drive(1'b1, 8);
        rst_sys_n = 1'b0;
        din_i     = 1'b0;
        @(posedge main_clk_buf); #1;
        chk("mid_reset_outputs", {7'b0, data_valid_o, err_o, frame_end_o, overflow_o, data_o}, 0);
        rst_sys_n = 1'b1;
        s_hs = hs_q.size();
        drive(1'b0, 1250);
        send_word(24'hABCDEF, 0);
        drive(1'b0, 1300);
        chk("mid_reset_count", hs_q.size() - s_hs, 1);
        chk("mid_reset_word", hs_q[hs_q.size() - 1], {1'b1, 24'hABCDEF});

        // pixel-chain forwarding: 744 cycles per nominal word
        s_pt = din_h.size();
        send_word(24'h0F0F0F, 0);
        send_word(24'hF00F55, 0);
        send_word(24'h3C3CA5, 0);
        drive(1'b0, 1300);
`ifdef WS281X_RX_PASSTHRU_EN
        cnt = 0;
        for (int n = s_pt; n < s_pt + 744; n++) if (dout_h[n]) cnt++;
        chk("pt_word1_absorbed", cnt, 0);
        mism = 0; cnt = 0;
        for (int n = s_pt + 747; n < s_pt + 3 * 744 + 3; n++) begin
            if (dout_h[n] !== din_h[n - 3]) mism++;
            if (dout_h[n]) cnt++;
        end
        chk("pt_forward_match", mism, 0);
        chk("pt_forward_active", (cnt > 0), 1);
`else
        cnt = 0;
        for (int n = 0; n < dout_h.size(); n++) if (dout_h[n]) cnt++;
        chk("dout_tied_low", cnt, 0);
`endif
        chk("pulses_single_cycle", n_long, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
